is_array_ctrl: RTL and testbench

IS_ARRAY_CTRL -- requirements
Module: is_array_ctrl

---
 rtl/is_pkg.sv | 18 +
 rtl/is_valid_delay.sv | 33 +++
 rtl/is_array_ctrl.sv | 117 +++++++++++
 tb/tb_is_array_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/is_pkg.sv
// Shared definitions for the systolic array controller.
// FSM encodings and default array geometry.
package is_pkg;

    localparam int D_W_DEF   = 8;
    localparam int ROWS_DEF  = 4;
    localparam int COLS_DEF  = 4;
    localparam int LEN_W_DEF = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LOAD  = 3'd1;
    localparam state_t S_FEED  = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/is_valid_delay.sv
// Shift line that turns activation reads into per-column
// out_sum valids from the bottom PE row.
module is_valid_delay #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            din,
    output logic [COLS-1:0] col_valid
);

    localparam int DEPTH = ROWS + COLS - 1;

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    // sr[k] is din delayed by k+1 cycles
    for (genvar c = 0; c < COLS; c++) begin : g_tap
        assign col_valid[c] = sr[ROWS+c-1];
    end

endmodule

// File: rtl/is_array_ctrl.sv
// Sequencer for a weight-stationary systolic array:
// weight load, activation feed, drain and completion.
module is_array_ctrl
    import is_pkg::*;
#(
    parameter int D_W   = D_W_DEF,
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    abort,
    input  logic                    act_avail,
    output logic                    load_weight,
    output logic                    w_rd_en,
    output logic [$clog2(ROWS)-1:0] w_idx,
    output logic                    act_rd_en,
    output logic [LEN_W-1:0]        act_idx,
    output logic [COLS-1:0]         col_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int IW  = $clog2(ROWS);
    localparam int DL  = ROWS + COLS - 1;
    localparam int DCW = $clog2(ROWS + COLS);

    if (D_W < 1) begin : g_bad_dw
        $error("D_W must be positive");
    end

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [DCW-1:0]   dcnt;
    logic             zdone;
    logic             kill;
    logic [COLS-1:0]  taps;

    assign kill = abort && (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            len_q   <= '0;
            w_idx   <= '0;
            act_idx <= '0;
            dcnt    <= '0;
            zdone   <= 1'b0;
        end else begin
            zdone <= 1'b0;
            if (kill) begin
                state   <= S_IDLE;
                w_idx   <= '0;
                act_idx <= '0;
                dcnt    <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (len != '0) begin
                                state   <= S_LOAD;
                                len_q   <= len;
                                w_idx   <= IW'(ROWS - 1);
                                act_idx <= '0;
                            end else begin
                                zdone <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (w_idx == '0) state <= S_FEED;
                        else w_idx <= w_idx - IW'(1);
                    end
                    S_FEED: begin
                        if (act_avail) begin
                            if (act_idx == len_q - LEN_W'(1)) begin
                                state   <= S_DRAIN;
                                act_idx <= '0;
                                dcnt    <= '0;
                            end else begin
                                act_idx <= act_idx + LEN_W'(1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (dcnt == DCW'(DL - 1)) state <= S_DONE;
                        else dcnt <= dcnt + DCW'(1);
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign load_weight = (state == S_LOAD) && !kill;
    assign w_rd_en     = load_weight;
    assign act_rd_en   = (state == S_FEED) && act_avail && !kill;
    assign busy        = (state != S_IDLE);
    assign done        = ((state == S_DONE) && !kill) || zdone;
    assign col_valid   = taps & {COLS{!kill}};

    is_valid_delay #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort),
        .din       (act_rd_en),
        .col_valid (taps)
    );

endmodule

// File: tb/tb_is_array_ctrl.sv
// Directed, table-driven bench for is_array_ctrl
// with ROWS=COLS=4, LEN_W=8.
module tb_is_array_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       abort;
    logic       act_avail;
    logic       load_weight;
    logic       w_rd_en;
    logic [1:0] w_idx;
    logic       act_rd_en;
    logic [7:0] act_idx;
    logic [3:0] col_valid;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       start;
        logic [7:0] len;
        logic       abort;
        logic       avail;
        logic       chk;
        logic       lw;
        logic [1:0] widx;
        logic       ard;
        logic       aidx_chk;
        logic [7:0] aidx;
        logic [3:0] cv;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [0:23];
    int   n_tbl;

    always #5 clk = ~clk;

    is_array_ctrl #(
        .D_W   (8),
        .ROWS  (4),
        .COLS  (4),
        .LEN_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .abort       (abort),
        .act_avail   (act_avail),
        .load_weight (load_weight),
        .w_rd_en     (w_rd_en),
        .w_idx       (w_idx),
        .act_rd_en   (act_rd_en),
        .act_idx     (act_idx),
        .col_valid   (col_valid),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string nm, input int cyc,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic check_zero(input string nm, input int cyc);
        chk({nm, ".lw"},   cyc, 32'(load_weight), 0);
        chk({nm, ".wrd"},  cyc, 32'(w_rd_en), 0);
        chk({nm, ".widx"}, cyc, 32'(w_idx), 0);
        chk({nm, ".ard"},  cyc, 32'(act_rd_en), 0);
        chk({nm, ".aidx"}, cyc, 32'(act_idx), 0);
        chk({nm, ".cv"},   cyc, 32'(col_valid), 0);
        chk({nm, ".busy"}, cyc, 32'(busy), 0);
        chk({nm, ".done"}, cyc, 32'(done), 0);
    endtask

    // Expected job timeline: load 1-4, reads from 5,
    // col_valid[c] = read delayed 4+c, done 8 after last read.
    task automatic build_job(input int l, input int bubble);
        logic rd [0:31];
        int   last;
        int   cnt;
        last = 4 + l + ((bubble >= 0) ? 1 : 0);
        for (int k = 0; k < 32; k++)
            rd[k] = (k >= 5 && k <= last && k != bubble);
        n_tbl = last + 10;
        cnt = 0;
        for (int k = 0; k < n_tbl; k++) begin
            tbl[k] = '{default: 0};
            tbl[k].start    = (k == 0);
            tbl[k].len      = 8'(l);
            tbl[k].avail    = (k != bubble);
            tbl[k].chk      = 1'b1;
            tbl[k].lw       = (k >= 1 && k <= 4);
            tbl[k].widx     = tbl[k].lw ? 2'(4 - k) : 2'd0;
            tbl[k].ard      = rd[k];
            tbl[k].aidx_chk = (k >= 5 && k <= last);
            tbl[k].aidx     = 8'(cnt);
            if (rd[k]) cnt++;
            for (int c = 0; c < 4; c++)
                tbl[k].cv[c] = (k - 4 - c >= 0) ? rd[k-4-c] : 1'b0;
            tbl[k].busy = (k >= 1 && k <= last + 8);
            tbl[k].done = (k == last + 8);
        end
    endtask

    task automatic run_table(input string nm);
        for (int k = 0; k < n_tbl; k++) begin
            start     = tbl[k].start;
            len       = tbl[k].len;
            abort     = tbl[k].abort;
            act_avail = tbl[k].avail;
            #2;
            if (tbl[k].chk) begin
                chk({nm, ".lw"},   k, 32'(load_weight), 32'(tbl[k].lw));
                chk({nm, ".wrd"},  k, 32'(w_rd_en), 32'(tbl[k].lw));
                chk({nm, ".widx"}, k, 32'(w_idx), 32'(tbl[k].widx));
                chk({nm, ".ard"},  k, 32'(act_rd_en), 32'(tbl[k].ard));
                if (tbl[k].aidx_chk)
                    chk({nm, ".aidx"}, k, 32'(act_idx), 32'(tbl[k].aidx));
                chk({nm, ".cv"},   k, 32'(col_valid), 32'(tbl[k].cv));
                chk({nm, ".busy"}, k, 32'(busy), 32'(tbl[k].busy));
                chk({nm, ".done"}, k, 32'(done), 32'(tbl[k].done));
            end
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        abort     = 1'b0;
        act_avail = 1'b0;
        len       = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=0 got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        len       = '0;
        abort     = 1'b0;
        act_avail = 1'b0;
        #2;
        check_zero("reset", 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        build_job(3, -1);
        run_table("job3");

        build_job(3, -1);
        tbl[3].start = 1'b1;
        tbl[3].len   = 8'd7;
        run_table("restart_ignored");

        build_job(3, 6);
        run_table("bubble");

        start = 1'b1;
        len   = 8'd0;
        #2;
        chk("len0.busy", 0, 32'(busy), 0);
        chk("len0.done", 0, 32'(done), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        #2;
        chk("len0.done", 1, 32'(done), 1);
        chk("len0.busy", 1, 32'(busy), 0);
        chk("len0.lw",   1, 32'(load_weight), 0);
        @(posedge clk);
        #1;
        #2;
        chk("len0.done", 2, 32'(done), 0);
        chk("len0.busy", 2, 32'(busy), 0);
        chk("len0.lw",   2, 32'(load_weight), 0);
        @(posedge clk);
        #1;

        build_job(3, -1);
        for (int k = 0; k < n_tbl; k++) tbl[k].avail = 1'b1;
        tbl[6].abort = 1'b1;
        tbl[6].chk   = 1'b0;
        for (int k = 7; k < n_tbl; k++) begin
            tbl[k].lw       = 1'b0;
            tbl[k].widx     = 2'd0;
            tbl[k].ard      = 1'b0;
            tbl[k].aidx_chk = 1'b1;
            tbl[k].aidx     = 8'd0;
            tbl[k].cv       = 4'd0;
            tbl[k].busy     = 1'b0;
            tbl[k].done     = 1'b0;
        end
        run_table("abort");

        build_job(3, -1);
        run_table("after_abort");

        build_job(3, -1);
        n_tbl = 8;
        run_table("pre_rst");
        act_avail = 1'b1;
        #2;
        chk("pre_rst.busy", 8, 32'(busy), 1);
        rst = 1'b0;
        #1;
        check_zero("async_rst", 8);
        @(posedge clk);
        #1;
        check_zero("rst_hold", 9);
        act_avail = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        build_job(3, -1);
        run_table("after_rst");

        start     = 1'b1;
        len       = 8'd255;
        act_avail = 1'b1;
        for (int k = 0; k <= 268; k++) begin
            #2;
            if (k >= 5 && k <= 259) begin
                chk("maxlen.ard",  k, 32'(act_rd_en), 1);
                chk("maxlen.aidx", k, 32'(act_idx), 32'(k - 5));
            end
            if (k == 260)
                chk("maxlen.ard", k, 32'(act_rd_en), 0);
            chk("maxlen.done", k, 32'(done), 32'(k == 267));
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        act_avail = 1'b0;
        #2;
        chk("maxlen.busy", 269, 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
